uart_rx: RTL

- 16x-oversampled UART receiver; consumes the 16x rx tick (`rxclk_en`) from the baud rate generator, one pulse per 1/16 bit.
- Deserialises 8N1 frames (optional parity) from the asynchronous `rx` pin into a one-entry holding register.
- Holding register is read through a valid/ready handshake by the command parser downstream.
- Reports framing, overrun (and parity) errors.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_if.sv | 47 ++++
 rtl/uart_rx_sync.sv | 38 +++
 rtl/uart_rx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the 16x-oversampled UART
//               receiver: receiver FSM state encoding and oversampling
//               tick positions.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Oversampling geometry: 16 ticks per bit; start bit is qualified at its
  // middle, later bits are sampled one full bit period after that point.
  localparam int OVERSAMPLE        = 16;
  localparam int MID_TICK          = 7;
  localparam int LAST_TICK         = 15;
  localparam int DEFAULT_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Receive-side handshake bundle between uart_rx and its
//               consumer (command parser).
//   rx_data     : received word, stable while rx_valid=1
//   rx_valid    : holding register full
//   rx_ready    : consumer accepts rx_data when rx_valid && rx_ready
//   framing_err : one-cycle pulse, stop bit sampled low
//   overrun_err : one-cycle pulse, completed word dropped (holding reg full)
//   parity_err  : one-cycle pulse, parity mismatch (0 unless parity built in)
//   Modports    : master = receiver side, slave = consumer side
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 framing_err;
  logic                 overrun_err;
  logic                 parity_err;

  modport master (
    output rx_data,
    output rx_valid,
    output framing_err,
    output overrun_err,
    output parity_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  framing_err,
    input  overrun_err,
    input  parity_err,
    output rx_ready
  );

endinterface : uart_rx_if
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for a single asynchronous input.
//               Reset value is a parameter so idle-high lines do not show
//               a false edge coming out of reset.
//   clk       : destination clock
//   rst       : synchronous active-high reset
//   async_i   : asynchronous input
//   sync_o    : synchronised output (2 clocks of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 16x-oversampled UART receiver. Deserialises LSB-first frames
//               from the asynchronous rx pin into a one-entry holding
//               register read through a valid/ready handshake; reports
//               framing, overrun and (optionally) parity errors.
//   clk_50m   : system clock
//   rst       : synchronous active-high reset
//   rxclk_en  : 16x oversample tick (one-cycle pulse)
//   rx        : asynchronous serial line, idle high
//   rx_if     : uart_rx_if.master (rx_data/rx_valid/rx_ready + error pulses)
//   Build option: define UART_RX_PARITY_EN to add a parity bit between the
//               data bits and the stop bit (sense set by PARITY_ODD).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int PARITY_ODD = 0
) (
  input  wire       clk_50m,
  input  wire       rst,
  input  wire       rxclk_en,
  input  wire       rx,
  uart_rx_if.master rx_if
);

  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx: DATA_BITS must be 5..8 and PARITY_ODD 0 or 1");
  end

  logic                 rx_s;
  rx_state_t            state_q;
  logic [TCW-1:0]       tick_cnt_q;
  logic [BCW-1:0]       bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 framing_err_q;
  logic                 overrun_err_q;
  logic                 parity_err_q;

  logic                 w_stop_tick;
  logic                 w_par_bad;
  logic                 w_commit;

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk     (clk_50m),
    .rst     (rst),
    .async_i (rx),
    .sync_o  (rx_s)
  );

  // The stop-bit sampling tick is the single point where a frame resolves:
  // it either commits the word or raises framing/parity errors.
  assign w_stop_tick = rxclk_en && (state_q == STOP) && (tick_cnt_q == TCW'(LAST_TICK));

`ifdef UART_RX_PARITY_EN
  logic par_bit_q;
  assign w_par_bad = ((^shift_q) ^ 1'(PARITY_ODD)) != par_bit_q;
`else
  assign w_par_bad = 1'b0;
`endif

  assign w_commit = w_stop_tick && rx_s && !w_par_bad;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
      parity_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q     <= 1'b0;
`endif
    end else begin
      framing_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
      parity_err_q  <= 1'b0;

      if (rxclk_en) begin
        case (state_q)
          IDLE: begin
            if (!rx_s) begin
              state_q    <= START;
              tick_cnt_q <= '0;
            end
          end

          START: begin
            if (tick_cnt_q == TCW'(MID_TICK)) begin
              // Still low at mid start bit: genuine start. High: glitch.
              tick_cnt_q <= '0;
              if (!rx_s) begin
                state_q   <= DATA;
                bit_cnt_q <= '0;
              end else begin
                state_q   <= IDLE;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end

          DATA: begin
            tick_cnt_q <= tick_cnt_q + 1'b1;  // wraps 15 -> 0 between bits
            if (tick_cnt_q == TCW'(LAST_TICK)) begin
              // Shift in at the MSB so the first (LSB) bit ends at bit 0.
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end

          PARITY: begin
`ifdef UART_RX_PARITY_EN
            tick_cnt_q <= tick_cnt_q + 1'b1;
            if (tick_cnt_q == TCW'(LAST_TICK)) begin
              par_bit_q <= rx_s;
              state_q   <= STOP;
            end
`else
            state_q <= IDLE;
`endif
          end

          STOP: begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
            if (tick_cnt_q == TCW'(LAST_TICK)) begin
              // Leave mid-stop so a back-to-back start edge is not missed.
              if (rx_s) begin
                state_q <= IDLE;
              end else begin
                state_q       <= BREAK;
                framing_err_q <= 1'b1;
              end
              if (w_par_bad) begin
                parity_err_q <= 1'b1;
              end
            end
          end

          BREAK: begin
            // Line must return high before another start can be armed.
            if (rx_s) begin
              state_q <= IDLE;
            end
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end

      // Holding register: a commit wins over a plain consume; a commit with
      // a simultaneous consume replaces the word without an overrun.
      if (w_commit) begin
        if (!valid_q || rx_if.rx_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_err_q <= 1'b1;
        end
      end else if (valid_q && rx_if.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data     = data_q;
  assign rx_if.rx_valid    = valid_q;
  assign rx_if.framing_err = framing_err_q;
  assign rx_if.overrun_err = overrun_err_q;
  assign rx_if.parity_err  = parity_err_q;

endmodule : uart_rx
`default_nettype wire
